// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - synchronise, debounce and pulse-shape the raw pet board inputs
//
// Purpose: turns four active-low push-buttons and one light comparator into
//   clean single-cycle active-high event pulses for the pet-state FSM.
//   Every input gets a 2-FF synchroniser followed by a stable-run debouncer.
//   Feed/heal/select pulse on a debounced press; test pulses only after a
//   long debounced hold; light pulses on entering dark and then periodically.
//
// Ports:
//   clk           in   system clock
//   rst           in   asynchronous reset, active low
//   btn_feed_n    in   raw feed button, 0 = pressed
//   btn_heal_n    in   raw heal button, 0 = pressed
//   btn_state_n   in   raw select button, 0 = pressed
//   btn_test_n    in   raw test button, 0 = pressed
//   light_raw     in   raw light comparator, 1 = dark
//   feeding       out  one-cycle pulse per accepted feed press
//   healing       out  one-cycle pulse per accepted heal press
//   change_state  out  one-cycle pulse per accepted select press
//   test          out  one-cycle pulse per qualifying long test press
//   light_out     out  pulse on entering dark, then every LIGHT_REPEAT_CYCLES while dark

module input_conditioner #(
  parameter int DEBOUNCE_CYCLES     = 1_000_000,
  parameter int TEST_HOLD_CYCLES    = 250_000_000,
  parameter int LIGHT_REPEAT_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_feed_n,
  input  logic btn_heal_n,
  input  logic btn_state_n,
  input  logic btn_test_n,
  input  logic light_raw,
  output logic feeding,
  output logic healing,
  output logic change_state,
  output logic test,
  output logic light_out
);

  localparam int NCH    = 5;
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(TEST_HOLD_CYCLES + 1);
  localparam int REP_W  = $clog2(LIGHT_REPEAT_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_LAST       = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST     = HOLD_W'(TEST_HOLD_CYCLES - 1);
  // test is registered, so it is set on the edge where the count steps onto HOLD_LAST
  localparam logic [HOLD_W-1:0] HOLD_PULSE_AT = HOLD_W'(TEST_HOLD_CYCLES - 2);
  localparam logic [REP_W-1:0]  REP_LAST      = REP_W'(LIGHT_REPEAT_CYCLES - 1);

  // Channel bit positions inside the packed vectors below
  localparam int CH_FEED  = 4;
  localparam int CH_HEAL  = 3;
  localparam int CH_STATE = 2;
  localparam int CH_TEST  = 1;
  localparam int CH_LIGHT = 0;

  // Raw-polarity "released" levels: buttons high, light bright (low)
  localparam logic [NCH-1:0] IDLE_LEVEL = 5'b11110;

  typedef enum logic {
    BRIGHT,
    DARK
  } light_state_t;

  logic [NCH-1:0]  raw;
  logic [NCH-1:0]  sync_meta;
  logic [NCH-1:0]  sync_out;
  logic [NCH-1:0]  deb;
  logic [2:0]      btn_prev;
  logic [DB_W-1:0] db_cnt [NCH];
  logic [HOLD_W-1:0] hold_cnt;
  logic [REP_W-1:0]  rep_cnt;
  light_state_t      light_state;

  assign raw = {btn_feed_n, btn_heal_n, btn_state_n, btn_test_n, light_raw};

  // Two-flop synchroniser; the first stage feeds only the second stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_meta <= IDLE_LEVEL;
      sync_out  <= IDLE_LEVEL;
    end else begin
      sync_meta <= raw;
      sync_out  <= sync_meta;
    end
  end

  // Debounce: a new level is accepted only after DEBOUNCE_CYCLES consecutive
  // samples that differ from the current debounced level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb <= IDLE_LEVEL;
      for (int i = 0; i < NCH; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (sync_out[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          deb[i]    <= sync_out[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Press pulses: released (1) -> pressed (0) edge on the debounced level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_prev     <= 3'b111;
      feeding      <= 1'b0;
      healing      <= 1'b0;
      change_state <= 1'b0;
    end else begin
      btn_prev     <= deb[CH_FEED:CH_STATE];
      feeding      <= btn_prev[2] & ~deb[CH_FEED];
      healing      <= btn_prev[1] & ~deb[CH_HEAL];
      change_state <= btn_prev[0] & ~deb[CH_STATE];
    end
  end

  // Test long-press: count debounced hold time, fire once, then saturate
  // until the button is released
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_cnt <= '0;
      test     <= 1'b0;
    end else if (deb[CH_TEST]) begin
      hold_cnt <= '0;
      test     <= 1'b0;
    end else begin
      if (hold_cnt != HOLD_LAST) begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end
      test <= (hold_cnt == HOLD_PULSE_AT);
    end
  end

  // Light FSM: pulse on entering dark, then once per repeat period while dark
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      light_state <= BRIGHT;
      rep_cnt     <= '0;
      light_out   <= 1'b0;
    end else begin
      case (light_state)
        BRIGHT: begin
          rep_cnt <= '0;
          if (deb[CH_LIGHT]) begin
            light_state <= DARK;
            light_out   <= 1'b1;
          end else begin
            light_out   <= 1'b0;
          end
        end
        DARK: begin
          if (!deb[CH_LIGHT]) begin
            light_state <= BRIGHT;
            rep_cnt     <= '0;
            light_out   <= 1'b0;
          end else if (rep_cnt == REP_LAST) begin
            rep_cnt   <= '0;
            light_out <= 1'b1;
          end else begin
            rep_cnt   <= rep_cnt + REP_W'(1);
            light_out <= 1'b0;
          end
        end
        default: begin
          light_state <= BRIGHT;
          rep_cnt     <= '0;
          light_out   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - randomized scoreboard bench for input_conditioner
module tb_input_conditioner;

  localparam int D    = 4;
  localparam int TH   = 20;
  localparam int LR   = 10;
  localparam int LAT  = 2 + D + 1;
  localparam int NCYC = 1500;

  logic clk = 1'b0;
  logic rst;
  logic btn_feed_n, btn_heal_n, btn_state_n, btn_test_n, light_raw;
  logic feeding, healing, change_state, test, light_out;

  input_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .TEST_HOLD_CYCLES(TH),
    .LIGHT_REPEAT_CYCLES(LR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_feed_n(btn_feed_n),
    .btn_heal_n(btn_heal_n),
    .btn_state_n(btn_state_n),
    .btn_test_n(btn_test_n),
    .light_raw(light_raw),
    .feeding(feeding),
    .healing(healing),
    .change_state(change_state),
    .test(test),
    .light_out(light_out)
  );

  always #5 clk = ~clk;

  // channel index: 0 feed, 1 heal, 2 state, 3 test, 4 light
  typedef struct {int ch; int start; int at;} gen_t;
  typedef struct {int ch; int at;} sb_t;

  gen_t gen_q[$];
  sb_t  sb_q[$];
  logic [4:0] wave [NCYC];   // 1 = asserted (pressed / dark)
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  bit mon_en = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic add_gen(input int ch, input int s, input int at);
    gen_t e;
    e.ch = ch; e.start = s; e.at = at;
    gen_q.push_back(e);
  endtask

  task automatic push_sb(input int ch, input int at);
    sb_t e;
    e.ch = ch; e.at = at;
    sb_q.push_back(e);
  endtask

  // Builds one channel's waveform as episodes of (idle, bounces, stable hold)
  // and records when each pulse must appear relative to the stable edge
  task automatic gen_channel(input int ch);
    int t, h, s, g, r, n, ep;
    t = 20; ep = 0;
    while (t + 120 < NCYC) begin
      if (ep > 0) t += $urandom_range(15, 6);
      n = 0;
      if (ch == 1 && ep == 0) n = 5;
      else if (ch <= 2 && ep > 0) n = $urandom_range(3, 0);
      for (int k = 0; k < n; k++) begin
        g = (ch == 1 && ep == 0) ? 2 : $urandom_range(D - 1, 1);
        r = (ch == 1 && ep == 0) ? 2 : $urandom_range(3, 1);
        for (int j = 0; j < g; j++) wave[t + j][ch] = 1'b1;
        t += g + r;
      end
      case (ch)
        0, 2: h = (ep == 0) ? 30 : $urandom_range(30, 5);
        1: h = $urandom_range(30, 5);
        3: begin
          if (ep == 0) h = 10;
          else if (ep == 1) h = 40;
          else h = ($urandom_range(1, 0) == 1) ? $urandom_range(15, 5) : $urandom_range(45, 24);
        end
        default: h = (ep == 0) ? 35 : $urandom_range(45, 5);
      endcase
      s = t;
      for (int j = 0; j < h; j++) wave[s + j][ch] = 1'b1;
      if (ch <= 2) begin
        add_gen(ch, s, s + LAT);
      end else if (ch == 3) begin
        // the debounced hold must last until the count reaches TH-1
        if (h >= TH - 1) add_gen(ch, s, s + 2 + D + (TH - 1));
      end else begin
        for (int k = 0; LR * k <= h - 1; k++) add_gen(ch, s, s + LAT + LR * k);
      end
      t = s + h;
      ep++;
    end
  endtask

  // Monitor: pops matching expectations whenever an output pulses
  always @(negedge clk) begin
    if (mon_en) begin
      logic [4:0] o;
      bit found;
      o = {light_out, test, change_state, healing, feeding};
      for (int i = sb_q.size() - 1; i >= 0; i--) begin
        if (sb_q[i].at < cyc) begin
          checks++; failures++;
          $display("FAIL missed_pulse ch=%0d cycle=%0d got=0 expected=1", sb_q[i].ch, sb_q[i].at);
          sb_q.delete(i);
        end
      end
      for (int ch = 0; ch < 5; ch++) begin
        if (o[ch]) begin
          checks++;
          found = 0;
          for (int i = 0; i < sb_q.size(); i++) begin
            if (!found && sb_q[i].ch == ch && sb_q[i].at == cyc) begin
              sb_q.delete(i);
              found = 1;
            end
          end
          if (!found) begin
            failures++;
            $display("FAIL unexpected_pulse ch=%0d cycle=%0d got=1 expected=0", ch, cyc);
          end
        end
      end
    end
  end

  initial begin
    int base, c0, c1;
    logic [4:0] outs;
    rst = 1'b0;
    btn_feed_n = 1'b1; btn_heal_n = 1'b1; btn_state_n = 1'b1; btn_test_n = 1'b1;
    light_raw = 1'b0;
    for (int c = 0; c < NCYC; c++) wave[c] = '0;
    for (int ch = 0; ch < 5; ch++) gen_channel(ch);

    repeat (3) @(negedge clk);
    outs = {light_out, test, change_state, healing, feeding};
    checks++;
    if (outs != 5'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b expected=00000", outs);
    end
    rst = 1'b1;
    mon_en = 1;

    // Randomized phase: apply one waveform slice per cycle, issuing expectations
    base = 0;
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      if (c == 0) base = cyc;
      btn_feed_n  = ~wave[c][0];
      btn_heal_n  = ~wave[c][1];
      btn_state_n = ~wave[c][2];
      btn_test_n  = ~wave[c][3];
      light_raw   =  wave[c][4];
      foreach (gen_q[i]) begin
        if (gen_q[i].start == c) push_sb(gen_q[i].ch, base + gen_q[i].at);
      end
    end

    // Reset while select and test are held; reset lands on the select pulse
    @(negedge clk);
    c0 = cyc;
    btn_state_n = 1'b0;
    btn_test_n  = 1'b0;
    push_sb(2, c0 + LAT);
    repeat (LAT) @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    outs = {light_out, test, change_state, healing, feeding};
    checks++;
    if (outs != 5'b0) begin
      failures++;
      $display("FAIL reset_mid_press got=%b expected=00000", outs);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    c1 = cyc;
    push_sb(2, c1 + LAT);
    push_sb(3, c1 + 2 + D + (TH - 1));
    repeat (40) @(negedge clk);
    btn_state_n = 1'b1;
    btn_test_n  = 1'b1;
    repeat (20) @(negedge clk);

    mon_en = 0;
    foreach (sb_q[i]) begin
      checks++; failures++;
      $display("FAIL pending_pulse ch=%0d cycle=%0d got=0 expected=1", sb_q[i].ch, sb_q[i].at);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
